// File: rtl/kernel_sink_pkg.sv
// Shared types and datapath helpers for the kernel output-stream sink.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package kernel_sink_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Words up to 32 bits; narrower words are zero-extended by the caller,
  // which leaves both the byte fold and the signature unaffected.
  function automatic logic [7:0] xor_fold_bytes(input logic [31:0] word);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ word[8*i +: 8];
    end
    return acc;
  endfunction

  function automatic logic [3:0] fold_nibble(input logic [7:0] b);
    return b[7:4] ^ b[3:0];
  endfunction

  // Rotate-left-by-one then XOR in the new word.
  function automatic logic [31:0] rot_xor(input logic [31:0] sig, input logic [31:0] word);
    return {sig[30:0], sig[31]} ^ word;
  endfunction

endpackage

// File: rtl/strm_fifo.sv
// Synchronous show-ahead FIFO holding stream words between kernel and drain.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered decodes.
module strm_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kernel_stream_sink.sv
// Sink for an HLS ap_fifo output stream: buffers, drains at a set rate, folds words to pins, signs the run.
// Latency: word written into an empty FIFO appears on data_out two edges after the push edge.
// Backpressure: strm_full_n low outside RUN/FLUSH or when FIFO is full; writes while low are dropped and flagged.
module kernel_stream_sink
  import kernel_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_INV  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] strm_din,
  input  logic                  strm_write,
  output logic                  strm_full_n,
  output logic [3:0]            data_out,
  output logic                  data_valid,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [31:0]           run_sig,
  output logic                  run_done,
  output logic                  overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = (DRAIN_INV > 1) ? $clog2(DRAIN_INV) : 1;
  localparam logic [CW-1:0] FULL_CNT     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(DRAIN_INV - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [TW-1:0]         r_timer;
  logic [7:0]            r_s1;
  logic                  r_s1_vld;
  logic [3:0]            r_data_out;
  logic                  r_data_valid;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [31:0]           r_run_sig;
  logic                  r_overflow;

  logic                  w_active;
  logic                  w_start;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_fifo_dout;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  assign w_active    = (r_state == RUN) || (r_state == FLUSH);
  assign w_start     = (r_state == IDLE) && ap_start;
  // Decoded from the registered count only, so it never depends on this cycle's pop.
  assign strm_full_n = w_active && (w_fifo_count != FULL_CNT);
  assign w_push      = strm_write && strm_full_n;
  assign w_pop       = w_active && !w_fifo_empty && (r_timer == '0);

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign word_cnt    = r_word_cnt;
  assign run_sig     = r_run_sig;
  assign run_done    = (r_state == DONE);
  assign overflow    = r_overflow;

  strm_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (strm_din),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Run-control state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state: FLUSH exits once nothing is buffered, arriving or in stage 1,
  // so the last data_valid cycle is immediately followed by run_done.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ap_start) w_state_nxt = RUN;
      RUN:     if (ap_done) w_state_nxt = FLUSH;
      FLUSH:   if (w_fifo_empty && !w_push && !r_s1_vld) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Drain timer: zero permits a pop, reloads on pop, counts down otherwise.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_timer <= '0;
    end else if (w_start) begin
      r_timer <= '0;
    end else if (w_pop) begin
      r_timer <= TIMER_RELOAD;
    end else if (w_active && (r_timer != '0)) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // Per-run word count (saturating) and rotating-XOR signature of popped words.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_word_cnt <= '0;
      r_run_sig  <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
      r_run_sig  <= '0;
    end else begin
      if (w_push && (r_word_cnt != '1)) r_word_cnt <= r_word_cnt + 1'b1;
      if (w_pop) r_run_sig <= rot_xor(r_run_sig, 32'(w_fifo_dout));
    end
  end

  // Two-stage fold: bytes to one byte on pop, then byte to nibble on the pins.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1         <= '0;
      r_s1_vld     <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_s1_vld <= w_pop;
      if (w_pop) r_s1 <= xor_fold_bytes(32'(w_fifo_dout));
      r_data_valid <= r_s1_vld;
      r_data_out   <= r_s1_vld ? fold_nibble(r_s1) : 4'h0;
    end
  end

  // Sticky overflow: in RUN/FLUSH strm_full_n is low only when full; DONE never accepts.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_overflow <= 1'b0;
    end else if (strm_write && ((r_state == DONE) || (w_active && w_fifo_full))) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kernel_stream_sink.sv
// Self-checking bench for kernel_stream_sink with a scoreboard of expected output nibbles.
// Latency: checks the two-edge push-to-pin path and the run_done timing.
// Backpressure: exercises full FIFO with slow drain, dropped writes and reset mid-run.
module tb_kernel_stream_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int DINV  = 4;
  localparam int CNTW  = 16;

  logic            ap_clk     = 1'b0;
  logic            ap_rst_n   = 1'b0;
  logic            ap_start   = 1'b0;
  logic            ap_done    = 1'b0;
  logic [DW-1:0]   strm_din   = '0;
  logic            strm_write = 1'b0;
  logic            strm_full_n;
  logic [3:0]      data_out;
  logic            data_valid;
  logic [CNTW-1:0] word_cnt;
  logic [31:0]     run_sig;
  logic            run_done;
  logic            overflow;

  kernel_stream_sink #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DRAIN_INV  (DINV),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .strm_din    (strm_din),
    .strm_write  (strm_write),
    .strm_full_n (strm_full_n),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .word_cnt    (word_cnt),
    .run_sig     (run_sig),
    .run_done    (run_done),
    .overflow    (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_tests     = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          last_dv_cyc = -1;
  int          dv_seen     = 0;
  bit          chk_spacing = 1'b0;
  logic [3:0]  exp_q[$];
  logic [31:0] m_sig       = '0;
  int          m_cnt       = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_nibble(input logic [31:0] w);
    logic [7:0] b;
    b = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    return b[7:4] ^ b[3:0];
  endfunction

  // Output monitor: every data_valid must match the oldest accepted word.
  always @(negedge ap_clk) begin
    if (ap_rst_n && data_valid) begin
      if (exp_q.size() == 0) check_eq("sb_nonempty_on_dv", 32'(exp_q.size()), 32'd1);
      else                   check_eq("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      if (chk_spacing && last_dv_cyc >= 0) check_eq("dv_spacing", 32'(cyc - last_dv_cyc), 32'(DINV));
      last_dv_cyc = cyc;
      dv_seen++;
    end
  end

  // One cycle of stimulus; acceptance is decided from the pre-edge strm_full_n.
  task automatic drive(input logic wr, input logic [31:0] d);
    strm_write = wr;
    strm_din   = d;
    if (wr && strm_full_n) begin
      exp_q.push_back(ref_nibble(d));
      m_sig = {m_sig[30:0], m_sig[31]} ^ d;
      m_cnt++;
    end
    @(negedge ap_clk);
  endtask

  task automatic start_run();
    ap_start    = 1'b1;
    m_sig       = '0;
    m_cnt       = 0;
    last_dv_cyc = -1;
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input bit pulse_done, input bit chk_gap);
    bit found;
    int done_cyc;
    if (pulse_done) begin
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
    end
    found    = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      if (run_done) begin
        found    = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge ap_clk);
    end
    check_eq({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      if (chk_gap) check_eq({tag, "_done_after_dv"}, 32'(done_cyc - last_dv_cyc), 32'd1);
      check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'(m_cnt));
      check_eq({tag, "_run_sig"}, run_sig, m_sig);
      check_eq({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
      @(negedge ap_clk);
      check_eq({tag, "_done_one_cycle"}, 32'(run_done), 32'd0);
      check_eq({tag, "_idle_full_n"}, 32'(strm_full_n), 32'd0);
    end
  endtask

  // Word written into an empty FIFO: invisible after edges 0 and 1, on the pins after edge 2.
  task automatic fold_one(input string tag, input logic [31:0] w, input logic [3:0] expn);
    drive(1'b1, w);
    strm_write = 1'b0;
    check_eq({tag, "_dv_e0"}, 32'(data_valid), 32'd0);
    @(negedge ap_clk);
    check_eq({tag, "_dv_e1"}, 32'(data_valid), 32'd0);
    @(negedge ap_clk);
    check_eq({tag, "_dv_e2"}, 32'(data_valid), 32'd1);
    check_eq({tag, "_nibble"}, 32'(data_out), 32'(expn));
    repeat (4) @(negedge ap_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_full_n"}, 32'(strm_full_n), 32'd0);
    check_eq({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    check_eq({tag, "_run_sig"}, run_sig, 32'd0);
    check_eq({tag, "_run_done"}, 32'(run_done), 32'd0);
    check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int dv_base;
    bit seen_drop;

    // Reset and idle with no start.
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_all_zero("idle");

    // Fold path and first-word latency.
    start_run();
    check_eq("run_full_n", 32'(strm_full_n), 32'd1);
    fold_one("fold_a", 32'h1234_5678, 4'h8);
    fold_one("fold_b", 32'h0102_0304, 4'h4);
    fold_one("fold_c", 32'hFFFF_FFFF, 4'h0);
    finish_run("fold", 1'b1, 1'b0);

    // Signature: second word written in the same cycle as ap_done.
    start_run();
    drive(1'b1, 32'h0000_0001);
    ap_done = 1'b1;
    drive(1'b1, 32'h0000_0002);
    ap_done    = 1'b0;
    strm_write = 1'b0;
    finish_run("sig12", 1'b0, 1'b1);
    check_eq("sig12_value", run_sig, 32'h0000_0000);
    check_eq("sig12_cnt", 32'(word_cnt), 32'd2);

    start_run();
    drive(1'b1, 32'h0000_0001);
    strm_write = 1'b0;
    finish_run("sig1", 1'b1, 1'b1);
    check_eq("sig1_value", run_sig, 32'h0000_0001);

    // Backpressure: write whenever allowed, slow drain.
    start_run();
    chk_spacing = 1'b1;
    acc         = 0;
    seen_drop   = 1'b0;
    dv_base     = dv_seen;
    for (int i = 0; i < 2000 && acc < 40; i++) begin
      if (strm_full_n) begin
        drive(1'b1, $urandom());
        acc++;
      end else begin
        if (!seen_drop) begin
          seen_drop = 1'b1;
          check_eq("bp_net_entries", 32'(acc - (dv_seen - dv_base)), 32'(DEPTH));
        end
        drive(1'b0, 32'd0);
      end
    end
    strm_write = 1'b0;
    check_eq("bp_saw_full", 32'(seen_drop), 32'd1);
    finish_run("bp", 1'b1, 1'b1);
    chk_spacing = 1'b0;
    check_eq("bp_word_cnt_40", 32'(word_cnt), 32'd40);
    check_eq("bp_no_overflow", 32'(overflow), 32'd0);

    // Overflow: hold write high through full periods; dropped words never reach the pins.
    start_run();
    for (int i = 0; i < 30; i++) drive(1'b1, 32'(i * 7 + 3));
    strm_write = 1'b0;
    finish_run("ovf", 1'b1, 1'b1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_dropped_some", 32'(m_cnt < 30), 32'd1);

    start_run();
    drive(1'b1, 32'h0000_0055);
    strm_write = 1'b0;
    finish_run("post_ovf", 1'b1, 1'b1);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Reset with words buffered.
    start_run();
    for (int i = 0; i < 11; i++) drive(1'b1, $urandom());
    strm_write = 1'b0;
    ap_rst_n   = 1'b0;
    #1;
    exp_q.delete();
    check_all_zero("midrst");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    start_run();
    drive(1'b1, 32'hA5A5_0001);
    strm_write = 1'b0;
    finish_run("after_rst", 1'b1, 1'b1);
    check_eq("after_rst_cnt", 32'(word_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
